// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: opcodes, ALU codes, register-destination encodings and the
// per-stage control words of the pipelined MIPS control unit.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [2:0] ALU_ADD   = 3'd0;
    localparam logic [2:0] ALU_SUB   = 3'd1;
    localparam logic [2:0] ALU_FUNCT = 3'd2;
    localparam logic [2:0] ALU_AND   = 3'd3;
    localparam logic [2:0] ALU_OR    = 3'd4;
    localparam logic [2:0] ALU_SLT   = 3'd5;

    localparam logic [1:0] DST_RT  = 2'b00;
    localparam logic [1:0] DST_RD  = 2'b01;
    localparam logic [1:0] DST_R31 = 2'b10;

    // alu holds the widest code; the top level resizes it to ALU_OP_W
    typedef struct packed {
        logic       rw;
        logic [1:0] dst;
        logic       src;
        logic       zext;
        logic [2:0] alu;
        logic       mw;
        logic       m2r;
        logic       link;
        logic       illegal;
    } ctrl_word_t;

    typedef struct packed {
        logic valid;
        logic rw;
        logic mw;
        logic m2r;
        logic link;
        logic illegal;
    } mem_ctrl_t;

    typedef struct packed {
        logic valid;
        logic rw;
        logic m2r;
        logic link;
        logic illegal;
    } wb_ctrl_t;

endpackage

// File: rtl/ctrl_decoder.sv
// ctrl_decoder: combinational opcode to control-word decoder; unknown or
// disabled extended opcodes yield an all-zero word with only the illegal bit set.
module ctrl_decoder
    import mips_ctrl_pkg::*;
#(
    parameter int ALU_OP_W = 3,
    parameter bit EXT_OPS  = 1'b1
) (
    input  logic [5:0] i_opcode,
    output ctrl_word_t o_word,
    output logic       o_jump,
    output logic       o_branch,
    output logic       o_branch_ne
);

    if (ALU_OP_W < 2 || (ALU_OP_W < 3 && EXT_OPS)) begin : g_bad_width
        $error("ctrl_decoder: ALU_OP_W too narrow for the enabled instruction set");
    end

    always_comb begin
        o_word      = '0;
        o_jump      = 1'b0;
        o_branch    = 1'b0;
        o_branch_ne = 1'b0;
        case (i_opcode)
            OP_RTYPE: begin o_word.rw = 1'b1; o_word.dst = DST_RD; o_word.alu = ALU_FUNCT; end
            OP_LW:    begin o_word.rw = 1'b1; o_word.src = 1'b1; o_word.m2r = 1'b1; o_word.alu = ALU_ADD; end
            OP_SW:    begin o_word.mw = 1'b1; o_word.src = 1'b1; o_word.alu = ALU_ADD; end
            OP_BEQ:   begin o_branch = 1'b1; o_word.alu = ALU_SUB; end
            OP_ADDI:  begin o_word.rw = 1'b1; o_word.src = 1'b1; o_word.alu = ALU_ADD; end
            OP_J:     o_jump = 1'b1;
            OP_BNE:   if (EXT_OPS) begin o_branch_ne = 1'b1; o_word.alu = ALU_SUB; end
                      else o_word.illegal = 1'b1;
            OP_ANDI:  if (EXT_OPS) begin o_word.rw = 1'b1; o_word.src = 1'b1; o_word.zext = 1'b1; o_word.alu = ALU_AND; end
                      else o_word.illegal = 1'b1;
            OP_ORI:   if (EXT_OPS) begin o_word.rw = 1'b1; o_word.src = 1'b1; o_word.zext = 1'b1; o_word.alu = ALU_OR; end
                      else o_word.illegal = 1'b1;
            OP_SLTI:  if (EXT_OPS) begin o_word.rw = 1'b1; o_word.src = 1'b1; o_word.alu = ALU_SLT; end
                      else o_word.illegal = 1'b1;
            OP_JAL:   if (EXT_OPS) begin o_jump = 1'b1; o_word.rw = 1'b1; o_word.dst = DST_R31; o_word.link = 1'b1; end
                      else o_word.illegal = 1'b1;
            default:  o_word.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/control_pipeline.sv
// control_pipeline: ID-stage decode plus the ID/EX, EX/MEM and MEM/WB control
// registers, with bubble insertion on stall, flush or an empty ID slot.
module control_pipeline
    import mips_ctrl_pkg::*;
#(
    parameter int ALU_OP_W = 3,
    parameter bit EXT_OPS  = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [5:0]          opcode_d,
    input  logic                valid_d,
    input  logic                stall_d,
    input  logic                flush_e,
    output logic                jump_d,
    output logic                branch_d,
    output logic                branch_ne_d,
    output logic                illegal_d,
    output logic                valid_e,
    output logic                reg_wr_en_e,
    output logic [1:0]          reg_dst_sel_e,
    output logic                alu_src_sel_e,
    output logic                imm_zext_e,
    output logic [ALU_OP_W-1:0] alu_op_e,
    output logic                mem_wr_en_e,
    output logic                mem_to_reg_e,
    output logic                link_e,
    output logic                valid_m,
    output logic                reg_wr_en_m,
    output logic                mem_wr_en_m,
    output logic                mem_to_reg_m,
    output logic                link_m,
    output logic                valid_w,
    output logic                reg_wr_en_w,
    output logic                mem_to_reg_w,
    output logic                link_w,
    output logic                illegal_w
);

    ctrl_word_t w_dec;
    logic       w_jump;
    logic       w_branch;
    logic       w_branch_ne;
    logic       w_load;
    ctrl_word_t r_e;
    logic       r_e_valid;
    mem_ctrl_t  r_m;
    wb_ctrl_t   r_w;

    ctrl_decoder #(.ALU_OP_W(ALU_OP_W), .EXT_OPS(EXT_OPS)) u_dec (
        .i_opcode    (opcode_d),
        .o_word      (w_dec),
        .o_jump      (w_jump),
        .o_branch    (w_branch),
        .o_branch_ne (w_branch_ne)
    );

    assign jump_d      = valid_d & w_jump;
    assign branch_d    = valid_d & w_branch;
    assign branch_ne_d = valid_d & w_branch_ne;
    assign illegal_d   = valid_d & w_dec.illegal;
    assign w_load      = valid_d & ~stall_d & ~flush_e;

    // an illegal word is already all-zero apart from its illegal bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_e_valid <= 1'b0;
            r_e       <= '0;
            r_m       <= '0;
            r_w       <= '0;
        end else begin
            r_e_valid <= w_load;
            r_e       <= w_load ? w_dec : '0;
            r_m       <= '{valid: r_e_valid, rw: r_e.rw, mw: r_e.mw, m2r: r_e.m2r, link: r_e.link, illegal: r_e.illegal};
            r_w       <= '{valid: r_m.valid, rw: r_m.rw, m2r: r_m.m2r, link: r_m.link, illegal: r_m.illegal};
        end
    end

    assign valid_e       = r_e_valid;
    assign reg_wr_en_e   = r_e.rw;
    assign reg_dst_sel_e = r_e.dst;
    assign alu_src_sel_e = r_e.src;
    assign imm_zext_e    = r_e.zext;
    assign alu_op_e      = ALU_OP_W'(r_e.alu);
    assign mem_wr_en_e   = r_e.mw;
    assign mem_to_reg_e  = r_e.m2r;
    assign link_e        = r_e.link;
    assign valid_m       = r_m.valid;
    assign reg_wr_en_m   = r_m.rw;
    assign mem_wr_en_m   = r_m.mw;
    assign mem_to_reg_m  = r_m.m2r;
    assign link_m        = r_m.link;
    assign valid_w       = r_w.valid;
    assign reg_wr_en_w   = r_w.rw;
    assign mem_to_reg_w  = r_w.m2r;
    assign link_w        = r_w.link;
    assign illegal_w     = r_w.illegal;

endmodule

// File: tb/tb_control_pipeline.sv
// tb_control_pipeline: directed stimulus on an EXT_OPS=1 and an EXT_OPS=0
// instance, checked each cycle against a latency/history model of the decode table.
module tb_control_pipeline;

    typedef struct packed {
        logic       valid, rw;
        logic [1:0] dst;
        logic       src, zext;
        logic [2:0] alu;
        logic       mw, m2r, link, illegal, jump, br, bne;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] opcode_d = 6'd0;
    logic       valid_d = 1'b0, stall_d = 1'b0, flush_e = 1'b0;

    logic       a_jd, a_bd, a_bned, a_ild, a_ve, a_rwe, a_srce, a_zxe, a_mwe, a_m2re, a_lke;
    logic [1:0] a_dste;
    logic [2:0] a_alue;
    logic       a_vm, a_rwm, a_mwm, a_m2rm, a_lkm, a_vw, a_rww, a_m2rw, a_lkw, a_ilw;
    logic       b_jd, b_bd, b_bned, b_ild, b_ve, b_rwe, b_srce, b_zxe, b_mwe, b_m2re, b_lke;
    logic [1:0] b_dste;
    logic [2:0] b_alue;
    logic       b_vm, b_rwm, b_mwm, b_m2rm, b_lkm, b_vw, b_rww, b_m2rw, b_lkw, b_ilw;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    control_pipeline #(.ALU_OP_W(3), .EXT_OPS(1'b1)) u_ext (
        .clk(clk), .rst_n(rst_n), .opcode_d(opcode_d), .valid_d(valid_d), .stall_d(stall_d), .flush_e(flush_e),
        .jump_d(a_jd), .branch_d(a_bd), .branch_ne_d(a_bned), .illegal_d(a_ild),
        .valid_e(a_ve), .reg_wr_en_e(a_rwe), .reg_dst_sel_e(a_dste), .alu_src_sel_e(a_srce),
        .imm_zext_e(a_zxe), .alu_op_e(a_alue), .mem_wr_en_e(a_mwe), .mem_to_reg_e(a_m2re), .link_e(a_lke),
        .valid_m(a_vm), .reg_wr_en_m(a_rwm), .mem_wr_en_m(a_mwm), .mem_to_reg_m(a_m2rm), .link_m(a_lkm),
        .valid_w(a_vw), .reg_wr_en_w(a_rww), .mem_to_reg_w(a_m2rw), .link_w(a_lkw), .illegal_w(a_ilw)
    );

    control_pipeline #(.ALU_OP_W(3), .EXT_OPS(1'b0)) u_base (
        .clk(clk), .rst_n(rst_n), .opcode_d(opcode_d), .valid_d(valid_d), .stall_d(stall_d), .flush_e(flush_e),
        .jump_d(b_jd), .branch_d(b_bd), .branch_ne_d(b_bned), .illegal_d(b_ild),
        .valid_e(b_ve), .reg_wr_en_e(b_rwe), .reg_dst_sel_e(b_dste), .alu_src_sel_e(b_srce),
        .imm_zext_e(b_zxe), .alu_op_e(b_alue), .mem_wr_en_e(b_mwe), .mem_to_reg_e(b_m2re), .link_e(b_lke),
        .valid_m(b_vm), .reg_wr_en_m(b_rwm), .mem_wr_en_m(b_mwm), .mem_to_reg_m(b_m2rm), .link_m(b_lkm),
        .valid_w(b_vw), .reg_wr_en_w(b_rww), .mem_to_reg_w(b_m2rw), .link_w(b_lkw), .illegal_w(b_ilw)
    );

    // what each opcode must produce, straight from the instruction table
    function automatic exp_t model(input logic [5:0] op, input bit ext);
        exp_t x = '0;
        x.valid = 1'b1;
        case (op)
            6'b000000: begin x.rw = 1; x.dst = 2'b01; x.alu = 3'd2; end
            6'b100011: begin x.rw = 1; x.src = 1; x.m2r = 1; end
            6'b101011: begin x.mw = 1; x.src = 1; end
            6'b000100: begin x.br = 1; x.alu = 3'd1; end
            6'b001000: begin x.rw = 1; x.src = 1; end
            6'b000010: x.jump = 1;
            6'b000101: if (ext) begin x.bne = 1; x.alu = 3'd1; end else x.illegal = 1;
            6'b001100: if (ext) begin x.rw = 1; x.src = 1; x.zext = 1; x.alu = 3'd3; end else x.illegal = 1;
            6'b001101: if (ext) begin x.rw = 1; x.src = 1; x.zext = 1; x.alu = 3'd4; end else x.illegal = 1;
            6'b001010: if (ext) begin x.rw = 1; x.src = 1; x.alu = 3'd5; end else x.illegal = 1;
            6'b000011: if (ext) begin x.jump = 1; x.rw = 1; x.dst = 2'b10; x.link = 1; end else x.illegal = 1;
            default:   x.illegal = 1;
        endcase
        return x;
    endfunction

    // history of what entered EX at each post-reset edge
    logic [5:0] hist_op [0:1023];
    bit         hist_ld [0:1023];
    int         n = 0;
    int         first = 0;

    always @(posedge clk) if (rst_n) begin
        hist_op[n] = opcode_d;
        hist_ld[n] = valid_d && !stall_d && !flush_e;
        n++;
    end

    always @(negedge rst_n) first = n;

    function automatic exp_t stage(input int k, input bit ext);
        int idx = n - k;
        if (idx < first || idx < 0 || !hist_ld[idx]) return '0;
        return model(hist_op[idx], ext);
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    task automatic cmp_all(input bit ext, input string p, input logic [11:0] ae, input logic [4:0] am,
                           input logic [4:0] aw, input logic [3:0] aid);
        exp_t e = stage(1, ext), m = stage(2, ext), w = stage(3, ext), d = model(opcode_d, ext);
        chk({p, "_id"}, 16'(aid), valid_d ? 16'({d.jump, d.br, d.bne, d.illegal}) : 16'd0);
        chk({p, "_e"}, 16'(ae), 16'({e.valid, e.rw, e.dst, e.src, e.zext, e.alu, e.mw, e.m2r, e.link}));
        chk({p, "_m"}, 16'(am), 16'({m.valid, m.rw, m.mw, m.m2r, m.link}));
        chk({p, "_w"}, 16'(aw), 16'({w.valid, w.rw, w.m2r, w.link, w.illegal}));
    endtask

    always @(negedge clk) begin
        cmp_all(1'b1, "ext", {a_ve, a_rwe, a_dste, a_srce, a_zxe, a_alue, a_mwe, a_m2re, a_lke},
                {a_vm, a_rwm, a_mwm, a_m2rm, a_lkm}, {a_vw, a_rww, a_m2rw, a_lkw, a_ilw}, {a_jd, a_bd, a_bned, a_ild});
        cmp_all(1'b0, "base", {b_ve, b_rwe, b_dste, b_srce, b_zxe, b_alue, b_mwe, b_m2re, b_lke},
                {b_vm, b_rwm, b_mwm, b_m2rm, b_lkm}, {b_vw, b_rww, b_m2rw, b_lkw, b_ilw}, {b_jd, b_bd, b_bned, b_ild});
    end

    task automatic drive(input logic [5:0] op, input logic v, input logic s, input logic f);
        @(posedge clk);
        #1;
        opcode_d = op; valid_d = v; stall_d = s; flush_e = f;
        #1;
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) drive(6'd0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        chk("reset_ve", 16'(a_ve), 16'd0);
        chk("reset_rww", 16'(a_rww), 16'd0);
        chk("reset_ilw", 16'(a_ilw), 16'd0);

        drive(6'b100011, 1, 0, 0);
        drive(6'b101011, 1, 0, 0);
        drive(6'b001000, 1, 0, 0);
        drive(6'b000000, 1, 0, 0);
        chk("sw_mw_m", 16'(a_mwm), 16'd1);
        chk("lw_rw_w", 16'(a_rww), 16'd1);
        chk("lw_m2r_w", 16'(a_m2rw), 16'd1);
        idle(1);
        chk("r_alu_e", 16'(a_alue), 16'd2);
        chk("r_dst_e", 16'(a_dste), 16'd1);

        drive(6'b000011, 1, 0, 0);
        chk("jal_jump_d", 16'(a_jd), 16'd1);
        idle(1);
        chk("jal_dst_e", 16'(a_dste), 16'd2);
        idle(2);
        chk("jal_link_w", 16'(a_lkw), 16'd1);
        chk("jal_rw_w", 16'(a_rww), 16'd1);

        drive(6'b100011, 1, 0, 0);
        drive(6'b000000, 1, 1, 0);
        chk("lw_ve", 16'(a_ve), 16'd1);
        drive(6'b000000, 1, 1, 0);
        chk("stall1_ve", 16'(a_ve), 16'd0);
        drive(6'b000000, 1, 0, 0);
        chk("stall2_ve", 16'(a_ve), 16'd0);
        idle(1);
        chk("held_r_ve", 16'(a_ve), 16'd1);
        chk("held_r_alu", 16'(a_alue), 16'd2);

        drive(6'b000100, 1, 0, 0);
        chk("beq_branch_d", 16'(a_bd), 16'd1);
        drive(6'b001000, 1, 0, 1);
        idle(1);
        chk("flush_rw_e", 16'(a_rwe), 16'd0);
        idle(1);
        chk("flush_rw_m", 16'(a_rwm), 16'd0);
        idle(1);
        chk("flush_rw_w", 16'(a_rww), 16'd0);

        drive(6'b111111, 1, 0, 0);
        chk("ill_d", 16'(a_ild), 16'd1);
        idle(3);
        chk("ill_w", 16'(a_ilw), 16'd1);
        idle(1);
        chk("ill_w_end", 16'(a_ilw), 16'd0);

        drive(6'b000101, 1, 0, 0);
        chk("bne_ill_d_base", 16'(b_ild), 16'd1);
        chk("bne_br_d_ext", 16'(a_bned), 16'd1);
        idle(3);
        chk("bne_ill_w_base", 16'(b_ilw), 16'd1);
        chk("bne_ill_w_ext", 16'(a_ilw), 16'd0);

        drive(6'b001000, 1, 1, 1);
        idle(1);
        chk("stall_flush_ve", 16'(a_ve), 16'd0);

        drive(6'b100011, 1, 0, 0);
        idle(1);
        #1 rst_n = 1'b0;
        opcode_d = 6'b001000; valid_d = 1'b1;
        #1;
        chk("async_rw_e", 16'(a_rwe), 16'd0);
        chk("async_m2r_e", 16'(a_m2re), 16'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #2;
        chk("post_rst_rw_e", 16'(a_rwe), 16'd1);
        idle(5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
